sha256_mem_host: RTL
====================

Name: sha256_mem_host

Overview:
- Host-side companion to the SHA-256 hasher core.
- Owns the word memory that the hasher reads its message from and writes its digest into, and serves the hasher's memory port as the responder.
- On the host side, accepts a 20-word message stream, pulses start, waits for done, then streams the 8-word digest back out.
- Sits between the host bus and the hasher core.

Parameters:
- DEPTH, 64, number of 32-bit memory words.
- MSG_WORDS, 20, message words per job (640-bit, 2-block message).
- DIGEST_WORDS, 8, digest words read back.
- TIMEOUT_CYCLES, 4096, watchdog limit in RUN; used only with SHA_HOST_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- msg_base  in  16  message base word address, sampled on the first accepted word
- out_base  in  16  digest base word address, sampled on the first accepted word
- in_valid  in  1  host message word valid
- in_ready  out  1  block can accept a message word
- in_data  in  32  message word
- out_valid  out  1  digest word valid
- out_ready  in  1  host accepts the digest word
- out_data  out  32  digest word
- busy  out  1  high in any state except IDLE
- err  out  1  sticky error: address out of range or timeout
- start  out  1  one-cycle start pulse to the hasher
- done  in  1  hasher done (level)
- core_reset_n  out  1  reset to the hasher, synchronous low pulse
- message_addr  out  16  registered copy of msg_base
- output_addr  out  16  registered copy of out_base
- mem_we  in  1  hasher write enable
- mem_addr  in  16  hasher word address
- mem_write_data  in  32  hasher write data
- mem_read_data  out  32  registered read data

Behaviour:
Reset values (all outputs):
- in_ready=0, out_valid=0, out_data=0, busy=0, err=0, start=0.
- core_reset_n=0 during reset, 1 after.
- message_addr=0, output_addr=0, mem_read_data=0.
- Memory contents are not reset.

Hasher port:
- Read latency is exactly 1: mem_read_data at edge n+1 = mem[mem_addr presented at edge n].
- Reads are served in every state.
- Hasher writes commit only in RUN; outside RUN they are ignored. The hasher holds mem_we high after finishing, so this filtering is required.

Host access:
- Host writes and reads use the same array and are disjoint in time from hasher writes.

Address range:
- Any address >= DEPTH: reads return 0, writes are dropped, err is set (sticky until reset).

State machine IDLE -> LOAD -> START -> RUN -> DRAIN -> RECOV -> IDLE:
- IDLE: in_ready=1. On an accepted word: write mem[msg_base], latch msg_base/out_base, count=1, go to LOAD.
- LOAD: in_ready=1. Each accepted word writes mem[message_addr+count]. After MSG_WORDS words go to START. No backpressure.
- START: start=1 for exactly one cycle, then RUN.
- RUN: in_ready=0. Wait for done=1, then DRAIN with count=0.
- DRAIN:
  - Issue read of output_addr+count.
  - Next cycle, load out_data and set out_valid.
  - Hold out_data stable while out_valid && !out_ready.
  - On handshake, increment count and issue the next read.
  - Throughput is at most one word per 2 cycles.
  - After DIGEST_WORDS handshakes go to RECOV.
- RECOV: core_reset_n=0 for one cycle (the hasher's DONE state is terminal), then IDLE.

Latency and boundaries:
- First out_valid rises 2 edges after the edge at which done is sampled high.
- in_valid during START/RUN/DRAIN/RECOV is not accepted.
- done high in any state other than RUN is ignored.
- Address arithmetic wraps modulo 2^16 before the range check.
- reset_n asserted mid-job aborts immediately; the next job restarts at word 0.

Optional Feature:
- Macro: SHA_HOST_TIMEOUT_EN.
- Defined: a cycle counter runs in RUN. If done is not seen within TIMEOUT_CYCLES cycles, set err and go to RECOV (core reset pulse, then IDLE) with no output words.
- Undefined: RUN waits indefinitely; the counter is not instantiated.

Decomposition:
- Package sha_host_pkg: state enum, MSG_WORDS, DIGEST_WORDS, word type (32-bit).
- Sub-module sha_word_ram: single write port, registered read port with 1-cycle latency.
- The write mux (host vs. hasher) and the range check stay in the top module.

Test Plan:
- Load: msg_base=0, out_base=0x20, words 0x0..0x13 -> mem[0..19]=0..0x13, exactly one start pulse 1 cycle after the 20th word; a hasher stub reading addr 5 sees 0x5 on the next edge.
- Drain: the stub writes 0xA0+i to 0x20..0x27 and raises done -> out stream 0xA0..0xA7 in order with out_ready toggling every cycle, no drops or duplicates, then a one-cycle core_reset_n low.
- Range: the stub reads addr 70 (DEPTH=64) -> mem_read_data=0, err=1 and stays 1.
- Write filtering: during DRAIN the stub drives mem_we=1, addr 0, data 0xFFFFFFFF -> mem[0] stays 0x0.
- Reset mid-LOAD: reset_n low after 7 words, then 20 new words 0x100+i -> mem[0..19]=0x100..0x113, start pulses once.
- Timeout: with SHA_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=100, done held 0 -> err=1 after 100 RUN cycles, core_reset_n pulse, busy=0. Without the macro, busy stays 1.

Source files
------------

// File: rtl/sha_host_pkg.sv
// Shared types and constants for the SHA-256 host-side memory block.
package sha_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN,
    S_RECOV
  } state_t;

  localparam int MSG_WORDS    = 20;
  localparam int DIGEST_WORDS = 8;

  typedef logic [31:0] word_t;

  function automatic logic in_range(input logic [15:0] addr, input int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/sha_word_ram.sv
// Word RAM: one write port, two registered read ports with 1-cycle latency.
// A read port with its enable low returns zero, which covers out-of-range reads.
module sha_word_ram
  import sha_host_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic          ra_en,
  input  logic [AW-1:0] ra_addr,
  output word_t         ra_data,
  input  logic          rb_en,
  input  logic [AW-1:0] rb_addr,
  output word_t         rb_data
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ra_data <= '0;
      rb_data <= '0;
    end else begin
      ra_data <= ra_en ? mem[ra_addr] : '0;
      rb_data <= rb_en ? mem[rb_addr] : '0;
    end
  end

endmodule

// File: rtl/sha256_mem_host.sv
// Host-side memory owner and job sequencer for the SHA-256 hasher core.
// Optional RUN watchdog enabled by defining SHA_HOST_TIMEOUT_EN.
module sha256_mem_host
  import sha_host_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int MSG_WORDS      = sha_host_pkg::MSG_WORDS,
  parameter int DIGEST_WORDS   = sha_host_pkg::DIGEST_WORDS,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] msg_base,
  input  logic [15:0] out_base,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        err,
  output logic        start,
  input  logic        done,
  output logic        core_reset_n,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t      state;
  logic [7:0]  count;
  logic        rd_wait;

  logic        host_acc;
  logic        hash_wr;
  logic        wr_req;
  logic        wr_ok;
  logic        drain_rd;
  logic        range_fault;
  logic [15:0] host_addr;
  logic [15:0] drain_addr;
  logic [15:0] wr_addr;
  word_t       wr_data;
  word_t       rb_data;

`ifdef SHA_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  // Host and hasher writes never overlap in time, so one write port suffices.
  always_comb begin
    host_acc    = in_valid && in_ready;
    host_addr   = (state == S_IDLE) ? msg_base : message_addr + 16'(count);
    drain_addr  = output_addr + 16'(count);
    hash_wr     = mem_we && (state == S_RUN);
    wr_req      = hash_wr || host_acc;
    wr_addr     = hash_wr ? mem_addr : host_addr;
    wr_data     = hash_wr ? mem_write_data : in_data;
    wr_ok       = wr_req && in_range(wr_addr, DEPTH);
    drain_rd    = (state == S_DRAIN);
    range_fault = !in_range(mem_addr, DEPTH)
                  || (wr_req && !in_range(wr_addr, DEPTH))
                  || (drain_rd && !in_range(drain_addr, DEPTH));
  end

  sha_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_ok),
    .waddr   (wr_addr[AW-1:0]),
    .wdata   (wr_data),
    .ra_en   (in_range(mem_addr, DEPTH)),
    .ra_addr (mem_addr[AW-1:0]),
    .ra_data (mem_read_data),
    .rb_en   (drain_rd && in_range(drain_addr, DEPTH)),
    .rb_addr (drain_addr[AW-1:0]),
    .rb_data (rb_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      count        <= '0;
      rd_wait      <= 1'b0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      busy         <= 1'b0;
      err          <= 1'b0;
      start        <= 1'b0;
      core_reset_n <= 1'b0;
      message_addr <= '0;
      output_addr  <= '0;
`ifdef SHA_HOST_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      core_reset_n <= 1'b1;
      start        <= 1'b0;
      if (range_fault) err <= 1'b1;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (host_acc) begin
            message_addr <= msg_base;
            output_addr  <= out_base;
            count        <= 8'd1;
            busy         <= 1'b1;
            state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (host_acc) begin
            if (count == 8'(MSG_WORDS - 1)) begin
              count    <= '0;
              in_ready <= 1'b0;
              start    <= 1'b1;
              state    <= S_START;
            end else begin
              count <= count + 8'd1;
            end
          end
        end
        S_START: begin
          state <= S_RUN;
`ifdef SHA_HOST_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        S_RUN: begin
          if (done) begin
            count   <= '0;
            rd_wait <= 1'b1;
            state   <= S_DRAIN;
          end
`ifdef SHA_HOST_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            err          <= 1'b1;
            core_reset_n <= 1'b0;
            state        <= S_RECOV;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        // rd_wait covers the RAM's registered read before out_data can load.
        S_DRAIN: begin
          if (out_valid) begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (count == 8'(DIGEST_WORDS - 1)) begin
                count        <= '0;
                core_reset_n <= 1'b0;
                state        <= S_RECOV;
              end else begin
                count   <= count + 8'd1;
                rd_wait <= 1'b1;
              end
            end
          end else if (rd_wait) begin
            rd_wait <= 1'b0;
          end else begin
            out_data  <= rb_data;
            out_valid <= 1'b1;
          end
        end
        S_RECOV: begin
          busy     <= 1'b0;
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
